// File: rtl/dram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dram_ctrl_pkg
//   Shared definitions for the DRAM controller data path.
//   - serdes_state_t : state encoding of the data serializer/deserializer
//   - BUF_WRITE/READ : buffer direction values driven on buf_rw, shared with
//                      the controller FSM so both agree on the polarity
// ---------------------------------------------------------------------------
package dram_ctrl_pkg;

    typedef enum logic [1:0] {
        SERDES_IDLE     = 2'd0,
        SERDES_WR_SHIFT = 2'd1,
        SERDES_RD_SHIFT = 2'd2,
        SERDES_RD_HOLD  = 2'd3
    } serdes_state_t;

    localparam logic BUF_WRITE = 1'b1;
    localparam logic BUF_READ  = 1'b0;

endpackage

// File: rtl/serdes_bit_counter.sv
// ---------------------------------------------------------------------------
// serdes_bit_counter
//   Beat counter shared by the write and read paths of dram_data_serdes.
//   Ports:
//     clk, rst_b : rising-edge clock, asynchronous active-low reset
//     clear      : synchronous clear to 0 (takes priority over enable)
//     enable     : advance by one; wraps naturally since DATA_WIDTH is 2^n
//     count      : current bit index
//     last       : count is at DATA_WIDTH-1 (final beat of a word)
// ---------------------------------------------------------------------------
module serdes_bit_counter #(
    parameter  int DATA_WIDTH = 8,
    localparam int CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] count_q;

    // Clear wins over enable so a new word always starts at bit 0.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;
    assign last  = (count_q == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/dram_data_serdes.sv
// ---------------------------------------------------------------------------
// dram_data_serdes
//   Serializes L2 write words into single-bit DRAM column beats (LSB first)
//   and gathers single-bit read beats into an L2 response word.
//   Ports:
//     clk, rst_b                 : clock, asynchronous active-low reset
//     wr_valid/wr_ready/wr_data  : L2 write word handshake
//     rd_req_valid/rd_req_ready  : request to collect one read word
//     l2_rsp_valid/ready/data    : assembled read word towards L2
//     dram_rdy                   : bank can move one bit this cycle
//     beat_en                    : a bit moves this cycle
//     buf_rw                     : 1 = drive dram_dout (write), 0 = read
//     dram_dout / dram_din       : write bit / read bit
//     bit_idx                    : index of the current bit in the word
//     busy                       : any state other than idle
// ---------------------------------------------------------------------------
module dram_data_serdes
    import dram_ctrl_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    localparam int CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    output logic                  l2_rsp_valid,
    input  logic                  l2_rsp_ready,
    output logic [DATA_WIDTH-1:0] l2_rsp_data,
    input  logic                  dram_rdy,
    output logic                  beat_en,
    output logic                  buf_rw,
    output logic                  dram_dout,
    input  logic                  dram_din,
    output logic [CNT_W-1:0]      bit_idx,
    output logic                  busy
);

    serdes_state_t         state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [CNT_W-1:0]      cnt;
    logic                  cnt_last;
    logic                  cnt_clear;
    logic                  shifting;

    assign shifting  = (state == SERDES_WR_SHIFT) || (state == SERDES_RD_SHIFT);
    assign cnt_clear = (state == SERDES_IDLE) && (wr_valid || rd_req_valid);

    serdes_bit_counter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_bit_counter (
        .clk    (clk),
        .rst_b  (rst_b),
        .clear  (cnt_clear),
        .enable (beat_en),
        .count  (cnt),
        .last   (cnt_last)
    );

    // The read word including the bit arriving this cycle; used both to
    // update the shift register and to publish the finished word on the
    // final beat without waiting a cycle.
    always_comb begin
        rd_word      = shreg;
        rd_word[cnt] = dram_din;
    end

    // One word in flight at a time; a write request takes priority over a
    // simultaneous read request, which then stays pending.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state       <= SERDES_IDLE;
            shreg       <= '0;
            l2_rsp_data <= '0;
        end else begin
            case (state)
                SERDES_IDLE: begin
                    if (wr_valid) begin
                        shreg <= wr_data;
                        state <= SERDES_WR_SHIFT;
                    end else if (rd_req_valid) begin
                        shreg <= '0;
                        state <= SERDES_RD_SHIFT;
                    end
                end
                SERDES_WR_SHIFT: begin
                    if (dram_rdy) begin
                        shreg <= shreg >> 1;
                        if (cnt_last) begin
                            state <= SERDES_IDLE;
                        end
                    end
                end
                SERDES_RD_SHIFT: begin
                    if (dram_rdy) begin
                        shreg <= rd_word;
                        if (cnt_last) begin
                            l2_rsp_data <= rd_word;
                            state       <= SERDES_RD_HOLD;
                        end
                    end
                end
                SERDES_RD_HOLD: begin
                    if (l2_rsp_ready) begin
                        state <= SERDES_IDLE;
                    end
                end
                default: begin
                    state <= SERDES_IDLE;
                end
            endcase
        end
    end

    // Handshake and bank-side outputs are decoded from the state register.
    assign wr_ready     = (state == SERDES_IDLE);
    assign rd_req_ready = (state == SERDES_IDLE) && !wr_valid;
    assign l2_rsp_valid = (state == SERDES_RD_HOLD);
    assign beat_en      = shifting && dram_rdy;
    assign buf_rw       = (state == SERDES_WR_SHIFT) ? BUF_WRITE : BUF_READ;
    assign dram_dout    = (state == SERDES_WR_SHIFT) ? shreg[0] : 1'b0;
    assign bit_idx      = shifting ? cnt : '0;
    assign busy         = (state != SERDES_IDLE);

endmodule

// File: tb/tb_dram_data_serdes.sv
// ---------------------------------------------------------------------------
// tb_dram_data_serdes
//   Scoreboard bench for dram_data_serdes (DATA_WIDTH = 8). Stimulus pushes
//   the expected bank beats and read responses into queues; a monitor on the
//   falling edge pops and compares whenever a beat or response handshake
//   happens.
// ---------------------------------------------------------------------------
module tb_dram_data_serdes;

    typedef struct packed {
        logic       rw;
        logic [2:0] idx;
        logic       dout;
    } beat_t;

    logic       clk;
    logic       rst_b;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       rd_req_valid;
    logic       rd_req_ready;
    logic       l2_rsp_valid;
    logic       l2_rsp_ready;
    logic [7:0] l2_rsp_data;
    logic       dram_rdy;
    logic       beat_en;
    logic       buf_rw;
    logic       dram_dout;
    logic       dram_din;
    logic [2:0] bit_idx;
    logic       busy;

    logic [7:0] rd_src;
    beat_t      exp_beats[$];
    logic [7:0] exp_rsp[$];
    int         compared;
    int         mismatched;
    int         beat_cnt;

    dram_data_serdes #(
        .DATA_WIDTH(8)
    ) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .l2_rsp_valid (l2_rsp_valid),
        .l2_rsp_ready (l2_rsp_ready),
        .l2_rsp_data  (l2_rsp_data),
        .dram_rdy     (dram_rdy),
        .beat_en      (beat_en),
        .buf_rw       (buf_rw),
        .dram_dout    (dram_dout),
        .dram_din     (dram_din),
        .bit_idx      (bit_idx),
        .busy         (busy)
    );

    // Simple bank model: presents the source bit selected by the bit index.
    assign dram_din = rd_src[bit_idx];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: compares each beat and each response handshake with the
    // head of its expectation queue.
    always @(negedge clk) begin
        beat_t b;
        logic [7:0] r;
        if (rst_b) begin
            if (beat_en) begin
                beat_cnt++;
                check_output("beat_qualified_by_rdy", 32'(dram_rdy), 32'd1);
                if (exp_beats.size() == 0) begin
                    check_output("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    b = exp_beats.pop_front();
                    check_output("beat_buf_rw", 32'(buf_rw), 32'(b.rw));
                    check_output("beat_bit_idx", 32'(bit_idx), 32'(b.idx));
                    if (b.rw) begin
                        check_output("beat_dram_dout", 32'(dram_dout), 32'(b.dout));
                    end
                end
            end
            if (l2_rsp_valid && l2_rsp_ready) begin
                if (exp_rsp.size() == 0) begin
                    check_output("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    r = exp_rsp.pop_front();
                    check_output("rsp_data", 32'(l2_rsp_data), 32'(r));
                end
            end
        end
    end

    task automatic push_write(input logic [7:0] data, input logic [7:0] bits_lsb_first);
        beat_t b;
        for (int i = 0; i < 8; i++) begin
            b.rw   = 1'b1;
            b.idx  = 3'(i);
            b.dout = bits_lsb_first[i];
            exp_beats.push_back(b);
        end
        check_output("push_consistency", 32'(data), 32'(bits_lsb_first));
    endtask

    task automatic push_read();
        beat_t b;
        for (int i = 0; i < 8; i++) begin
            b.rw   = 1'b0;
            b.idx  = 3'(i);
            b.dout = 1'b0;
            exp_beats.push_back(b);
        end
    endtask

    // Runs cycles until the block goes idle; returns the cycle count.
    task automatic wait_idle(input bit toggle, output int cycles);
        cycles = 0;
        while (busy && cycles < 40) begin
            if (toggle) dram_rdy = ~dram_rdy;
            @(posedge clk);
            #1;
            cycles++;
        end
        dram_rdy = 1'b1;
        if (cycles >= 40) check_output("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic apply_stimulus_write(input logic [7:0] data, input logic [7:0] bits,
                                        input bit toggle);
        int cycles;
        beat_cnt = 0;
        push_write(data, bits);
        wr_data  = data;
        wr_valid = 1'b1;
        dram_rdy = 1'b1;
        #0;
        check_output("wr_ready_idle", 32'(wr_ready), 32'd1);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        check_output("wr_busy", 32'(busy), 32'd1);
        check_output("wr_buf_rw", 32'(buf_rw), 32'd1);
        wait_idle(toggle, cycles);
        if (!toggle) check_output("wr_latency", 32'(cycles), 32'd8);
        check_output("wr_beats", 32'(beat_cnt), 32'd8);
        check_output("wr_ready_after", 32'(wr_ready), 32'd1);
        check_output("wr_queue_empty", 32'(exp_beats.size()), 32'd0);
    endtask

    // Waits for the response, holds it for hold_cycles with ready low
    // (unless ready is already high), then completes the handshake.
    task automatic finish_read(input logic [7:0] expected, input int hold_cycles,
                               input int exp_latency);
        int cycles;
        cycles = 0;
        while (!l2_rsp_valid && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check_output("rd_latency", 32'(cycles), 32'(exp_latency));
        check_output("rd_rsp_data", 32'(l2_rsp_data), 32'(expected));
        for (int i = 0; i < hold_cycles; i++) begin
            @(posedge clk);
            #1;
            check_output("rd_hold_valid", 32'(l2_rsp_valid), 32'd1);
            check_output("rd_hold_data", 32'(l2_rsp_data), 32'(expected));
            check_output("rd_hold_no_beat", 32'(beat_en), 32'd0);
        end
        l2_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check_output("rd_valid_drop", 32'(l2_rsp_valid), 32'd0);
        check_output("rd_idle", 32'(busy), 32'd0);
        check_output("rd_queue_empty", 32'(exp_rsp.size()), 32'd0);
        l2_rsp_ready = 1'b0;
    endtask

    task automatic apply_stimulus_read(input logic [7:0] src, input logic [7:0] expected,
                                       input int hold_cycles, input bit ready_high);
        beat_cnt     = 0;
        rd_src       = src;
        push_read();
        exp_rsp.push_back(expected);
        l2_rsp_ready = ready_high;
        rd_req_valid = 1'b1;
        dram_rdy     = 1'b1;
        #0;
        check_output("rd_req_ready_idle", 32'(rd_req_ready), 32'd1);
        @(posedge clk);
        #1;
        rd_req_valid = 1'b0;
        check_output("rd_buf_rw", 32'(buf_rw), 32'd0);
        finish_read(expected, hold_cycles, 8);
        check_output("rd_beats", 32'(beat_cnt), 32'd8);
    endtask

    initial begin
        int cycles;
        compared     = 0;
        mismatched   = 0;
        beat_cnt     = 0;
        rst_b        = 1'b0;
        wr_valid     = 1'b0;
        wr_data      = 8'h00;
        rd_req_valid = 1'b0;
        l2_rsp_ready = 1'b0;
        dram_rdy     = 1'b1;
        rd_src       = 8'h00;

        // Reset state.
        #2;
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_buf_rw", 32'(buf_rw), 32'd0);
        check_output("rst_dout", 32'(dram_dout), 32'd0);
        check_output("rst_beat_en", 32'(beat_en), 32'd0);
        check_output("rst_rsp_valid", 32'(l2_rsp_valid), 32'd0);
        check_output("rst_rsp_data", 32'(l2_rsp_data), 32'd0);
        check_output("rst_bit_idx", 32'(bit_idx), 32'd0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;

        $display("[TB] write A5, rdy held");
        apply_stimulus_write(8'hA5, 8'b1010_0101, 1'b0);

        $display("[TB] read EC, ready low for 5 cycles");
        apply_stimulus_read(8'hEC, 8'hEC, 5, 1'b0);

        $display("[TB] write 3C, rdy toggling");
        apply_stimulus_write(8'h3C, 8'b0011_1100, 1'b1);

        $display("[TB] simultaneous write and read request");
        beat_cnt = 0;
        push_write(8'h96, 8'b1001_0110);
        push_read();
        exp_rsp.push_back(8'h5A);
        rd_src       = 8'h5A;
        wr_data      = 8'h96;
        wr_valid     = 1'b1;
        rd_req_valid = 1'b1;
        #0;
        check_output("both_wr_ready", 32'(wr_ready), 32'd1);
        check_output("both_rd_req_ready", 32'(rd_req_ready), 32'd0);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        check_output("both_buf_rw_write", 32'(buf_rw), 32'd1);
        wait_idle(1'b0, cycles);
        check_output("both_wr_latency", 32'(cycles), 32'd8);
        check_output("both_rd_req_ready_after", 32'(rd_req_ready), 32'd1);
        @(posedge clk);
        #1;
        rd_req_valid = 1'b0;
        check_output("both_read_started", 32'(busy), 32'd1);
        check_output("both_buf_rw_read", 32'(buf_rw), 32'd0);
        finish_read(8'h5A, 0, 8);
        check_output("both_beats", 32'(beat_cnt), 32'd16);

        $display("[TB] reset mid-read");
        beat_cnt     = 0;
        rd_src       = 8'h0F;
        push_read();
        rd_req_valid = 1'b1;
        @(posedge clk);
        #1;
        rd_req_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check_output("midrd_beats", 32'(beat_cnt), 32'd4);
        rst_b = 1'b0;
        #1;
        check_output("midrd_busy", 32'(busy), 32'd0);
        check_output("midrd_beat_en", 32'(beat_en), 32'd0);
        check_output("midrd_rsp_valid", 32'(l2_rsp_valid), 32'd0);
        check_output("midrd_rsp_data", 32'(l2_rsp_data), 32'd0);
        exp_beats.delete();
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        apply_stimulus_read(8'hFF, 8'hFF, 0, 1'b1);

        $display("[TB] back-to-back writes 01, 80");
        beat_cnt = 0;
        push_write(8'h01, 8'b0000_0001);
        push_write(8'h80, 8'b1000_0000);
        wr_data  = 8'h01;
        wr_valid = 1'b1;
        @(posedge clk);
        #1;
        wr_data = 8'h80;
        wait_idle(1'b0, cycles);
        check_output("b2b_first_latency", 32'(cycles), 32'd8);
        check_output("b2b_idle_gap_ready", 32'(wr_ready), 32'd1);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        check_output("b2b_second_started", 32'(busy), 32'd1);
        wait_idle(1'b0, cycles);
        check_output("b2b_second_latency", 32'(cycles), 32'd8);
        check_output("b2b_beats", 32'(beat_cnt), 32'd16);
        check_output("b2b_queue_empty", 32'(exp_beats.size()), 32'd0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dram_data_serdes.md
Name: dram_data_serdes

Overview:
- Data-path stage between the DRAM controller's L2 side and the bit-wide DRAM bank interface (bank data width 1).
- Write path: serializes one DATA_WIDTH-bit L2 write word into DATA_WIDTH single-bit column beats, LSB first.
- Read path: gathers DATA_WIDTH read bits, LSB first, into one word and presents it to L2 as l2_rsp_data with a valid/ready handshake.
- Owns the buffer direction (buf_rw) and the bit index presented to the bank.

Parameters:
- DATA_WIDTH, 8: L2 word width; must be a power of two and at least 2.
- CNT_W, $clog2(DATA_WIDTH): beat counter / bit index width. Derived; do not override.

Ports:
- clk, input, 1: single clock; all logic is rising-edge.
- rst_b, input, 1: asynchronous active-low reset.
- wr_valid, input, 1: an L2 write word is offered.
- wr_ready, output, 1: the block accepts a write word.
- wr_data, input, DATA_WIDTH: the L2 write word.
- rd_req_valid, input, 1: a read-word collection is requested.
- rd_req_ready, output, 1: the block accepts the read request.
- l2_rsp_valid, output, 1: the assembled read word is valid.
- l2_rsp_ready, input, 1: L2 consumes the read word.
- l2_rsp_data, output, DATA_WIDTH: the assembled read word.
- dram_rdy, input, 1: the bank can take or give one bit this cycle.
- beat_en, output, 1: a bit transfer occurs this cycle (a strobe, always qualified by dram_rdy).
- buf_rw, output, 1: 1 means the block drives dram_dout (write); 0 means read.
- dram_dout, output, 1: the write bit.
- dram_din, input, 1: the read bit; sampled in the same cycle as the beat.
- bit_idx, output, CNT_W: index of the current bit within the word.
- busy, output, 1: high whenever the state is not IDLE.

Behaviour:
- States: IDLE, WR_SHIFT, RD_SHIFT, RD_HOLD. The state register is the only control source; handshake outputs are combinational from state.
- Reset (async, rst_b=0):
  - state goes to IDLE.
  - Shift registers, bit counter and l2_rsp_data go to 0.
  - l2_rsp_valid, beat_en, buf_rw, dram_dout and busy are 0.
  - The first handshake can complete on the first clk edge after rst_b rises.
  - A reset mid-transfer discards the partial word; no beat completes afterwards.
- IDLE:
  - wr_ready=1 and rd_req_ready=1.
  - If wr_valid=1: load wr_data into the write shift register, clear the counter, go to WR_SHIFT.
  - Else if rd_req_valid=1: clear the read shift register and counter, go to RD_SHIFT.
  - If both are valid in the same cycle, write wins. rd_req_ready is forced to 0 in that cycle, so the read request stays pending.
- WR_SHIFT:
  - wr_ready=0, rd_req_ready=0, buf_rw=1, bit_idx=counter, dram_dout=shreg[0].
  - beat_en = dram_rdy.
  - On a beat: shift the register right by 1 and increment the counter.
  - On the beat with counter==DATA_WIDTH-1: the counter wraps to 0 and the next state is IDLE.
  - dram_rdy=0 stalls with no change.
  - Latency: DATA_WIDTH cycles from acceptance with dram_rdy held high; back-to-back words are then separated by one IDLE cycle.
- RD_SHIFT:
  - buf_rw=0, bit_idx=counter, beat_en = dram_rdy.
  - On a beat: shreg[counter] <= dram_din and increment the counter.
  - After the beat with counter==DATA_WIDTH-1: copy the completed word into l2_rsp_data and go to RD_HOLD.
- RD_HOLD:
  - l2_rsp_valid=1; l2_rsp_data is stable until the handshake.
  - No beats occur; wr_ready=0 and rd_req_ready=0.
  - When l2_rsp_ready=1: go to IDLE. l2_rsp_valid drops the next cycle.
  - l2_rsp_ready may be held high continuously, in which case RD_HOLD lasts exactly one cycle.
- Outside an active state: buf_rw=0, dram_dout=0, bit_idx=0.
- No pipelining: exactly one word is in flight at a time.

Decomposition:
- Shared package dram_ctrl_pkg holds:
  - the state enum (SERDES_IDLE, SERDES_WR_SHIFT, SERDES_RD_SHIFT, SERDES_RD_HOLD);
  - the BUF_WRITE=1 and BUF_READ=0 constants, also used by dram_fsm.
- One sub-module, serdes_bit_counter: CNT_W-bit counter with clear, enable and a last-flag output (count==DATA_WIDTH-1). The write and read paths share a single instance.
- The rest is a single module.

Test Plan:
- Reset, then write 8'hA5 with dram_rdy=1 held:
  - accepted on the first edge after reset;
  - dram_dout over 8 beats is 1,0,1,0,0,1,0,1;
  - bit_idx runs 0..7 and buf_rw=1 throughout;
  - back in IDLE with wr_ready=1 after 8 cycles.
- Read with dram_din driving 0,0,1,1,0,1,1,1 and l2_rsp_ready=0:
  - l2_rsp_valid rises after the 8th beat with l2_rsp_data=8'hEC;
  - it holds for 5 cycles; l2_rsp_ready=1 completes the handshake and l2_rsp_valid drops on the next cycle.
- Write 8'h3C with dram_rdy toggling 1,0,1,0…: exactly 8 beats occur; beat_en never fires while dram_rdy=0; the serialized value is still 8'h3C.
- wr_valid and rd_req_valid asserted in the same IDLE cycle:
  - the write is accepted and rd_req_ready=0 in that cycle;
  - the read starts on the first IDLE cycle after the write completes.
- Assert rst_b=0 asynchronously mid-read after 4 beats:
  - busy, beat_en and l2_rsp_valid are 0 immediately and l2_rsp_data=0;
  - a subsequent full read of 8'hFF returns exactly 8'hFF.
- Back-to-back writes 8'h01 then 8'h80 with wr_valid held high: 8 beats, 1 IDLE cycle, 8 beats; the bit patterns are correct and the LSB goes first.
